mem_arbiter: RTL and testbench

Single-port data-memory arbiter for the myMIPS core. It shares one synchronous 256x16 memory port between three requesters: instruction fetch (IF), data load/store (DM) and the debug read port (DBG, the `rd`/`raddr`/`rdata` path). It grants one access per cycle using rotating priority. DM may lock the port for a bounded burst. Read data returns one cycle after grant with a per-requester valid pulse. The block sits in `top` between the core, the debug port and the memory macro.

---
 rtl/mips_pkg.sv | 16 +
 rtl/rr_pick3.sv | 30 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the myMIPS memory arbiter.
// Requester indices, arbiter state encoding and default widths.
package mips_pkg;
  localparam int REQ_IF = 0;
  localparam int REQ_DM = 1;
  localparam int REQ_DBG = 2;
  localparam int NREQ = 3;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;
endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way rotating-priority picker.
// Ports: req (3 requests), ptr (highest-priority index) -> win (one-hot), idx.
import mips_pkg::*;

module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic [1:0] idx
);

  logic found;
  int   p;

  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    p = 0;
    for (int k = 0; k < NREQ; k++) begin
      p = (int'(ptr) + k) % NREQ;
      if (!found && req[p]) begin
        found = 1'b1;
        win[p] = 1'b1;
        idx = 2'(p);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: IF, DM and DBG share one sync memory port.
// Ports: clk, int_rst, req/addr_*/we_dm/wdata_dm/lock_dm in; gnt, rvalid,
// rdata, mem_en/we/addr/wdata out; mem_rdata in (1-cycle latency).
import mips_pkg::*;

module mem_arbiter #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          int_rst,
  input  logic [2:0]    req,
  input  logic [AW-1:0] addr_if,
  input  logic [AW-1:0] addr_dm,
  input  logic [AW-1:0] addr_dbg,
  input  logic          we_dm,
  input  logic [DW-1:0] wdata_dm,
  input  logic          lock_dm,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_LOCK);

  arb_state_t    state, state_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    rv_q;
  logic [2:0]    gnt_c;
  logic [2:0]    pick;
  logic [1:0]    pidx;

  rr_pick3 u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick),
    .idx (pidx)
  );

  always_ff @(posedge clk or posedge int_rst) begin
    if (int_rst) begin
      state <= ARB;
      ptr   <= '0;
      cnt   <= '0;
      rv_q  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      // Writes return nothing, so the DM bit is masked by we_dm.
      rv_q  <= {gnt_c[REQ_DBG],
                gnt_c[REQ_DM] & ~we_dm,
                gnt_c[REQ_IF]};
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_c   = '0;
    unique case (state)
      ARB: begin
        gnt_c = pick;
        if (|req) begin
          ptr_n = (pidx == 2'd2) ? 2'd0 : pidx + 2'd1;
          if (pick[REQ_DM] && lock_dm && (MAX_LOCK > 1)) begin
            state_n = LOCK;
            cnt_n   = CW'(1);
          end
        end
      end
      LOCK: begin
        if (req[REQ_DM] && (cnt < CMAX)) begin
          gnt_c[REQ_DM] = 1'b1;
          cnt_n = cnt + CW'(1);
          if (!lock_dm || (cnt_n == CMAX)) begin
            state_n = ARB;
            ptr_n   = 2'(REQ_DBG);
            cnt_n   = '0;
          end
        end else begin
          // DM let go (or bound hit): no grant now, rotate from DBG next.
          state_n = ARB;
          ptr_n   = 2'(REQ_DBG);
          cnt_n   = '0;
        end
      end
      default: state_n = ARB;
    endcase
  end

  assign gnt    = int_rst ? 3'b000 : gnt_c;
  assign mem_en = |gnt;
  assign mem_we = gnt[REQ_DM] & we_dm;

  always_comb begin
    mem_addr = '0;
    if (gnt[REQ_IF])
      mem_addr = addr_if;
    else if (gnt[REQ_DM])
      mem_addr = addr_dm;
    else if (gnt[REQ_DBG])
      mem_addr = addr_dbg;
  end

  assign mem_wdata = int_rst ? '0 : wdata_dm;
  assign rvalid    = rv_q;
  assign rdata     = (|rv_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 256x16 memory.
// Directed vectors push expected read returns; a monitor pops on rvalid.
module tb_mem_arbiter;

  logic        clk;
  logic        int_rst;
  logic [2:0]  req;
  logic [7:0]  addr_if, addr_dm, addr_dbg;
  logic        we_dm;
  logic [15:0] wdata_dm;
  logic        lock_dm;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [256];

  int total = 0;
  int passed = 0;
  logic [18:0] exp_q [$];
  logic        done = 1'b0;

  mem_arbiter #(.AW(8), .DW(16), .MAX_LOCK(4)) dut (
    .clk       (clk),
    .int_rst   (int_rst),
    .req       (req),
    .addr_if   (addr_if),
    .addr_dm   (addr_dm),
    .addr_dbg  (addr_dbg),
    .we_dm     (we_dm),
    .wdata_dm  (wdata_dm),
    .lock_dm   (lock_dm),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we)
      mem[mem_addr] <= mem_wdata;
    else if (mem_en)
      mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req_v);
    total++;
    if (act === req_v)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, act, req_v);
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (!done && rvalid !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {13'd0, rvalid, rdata}, 32'd0);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("rvalid", 32'(rvalid), 32'(e[18:16]));
        check("rdata", 32'(rdata), 32'(e[15:0]));
      end
    end
  end

  // One cycle: drive at negedge, check combinational grant, push reads.
  task automatic cyc(input string name, input logic [2:0] r,
                     input logic l, input logic w,
                     input logic [2:0] eg, input logic [15:0] ed);
    req = r;
    lock_dm = l;
    we_dm = w;
    #1;
    check(name, 32'(gnt), 32'(eg));
    check({name, "_we"}, 32'(mem_we), 32'(eg[1] & w));
    if (eg != 3'b000 && !(eg[1] && w))
      exp_q.push_back({eg, ed});
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'hABCD;
    mem[8'h11] = 16'h1111;
    mem[8'h30] = 16'h3333;
    mem_rdata = '0;
    int_rst = 1'b1;
    req = 3'b111;
    addr_if = 8'h10;
    addr_dm = 8'h11;
    addr_dbg = 8'h30;
    we_dm = 1'b0;
    wdata_dm = 16'h5A5A;
    lock_dm = 1'b0;
    @(negedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_en", 32'(mem_en), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    @(negedge clk);
    int_rst = 1'b0;
    req = 3'b000;
    @(negedge clk);

    // IF read after reset, ptr -> 1
    cyc("if_read", 3'b001, 0, 0, 3'b001, 16'hABCD);
    // DBG read takes ptr from 1 to 0
    cyc("dbg_ptr0", 3'b100, 0, 0, 3'b100, 16'h3333);
    // round robin from ptr 0
    cyc("rr0", 3'b111, 0, 0, 3'b001, 16'hABCD);
    cyc("rr1", 3'b111, 0, 0, 3'b010, 16'h1111);
    cyc("rr2", 3'b111, 0, 0, 3'b100, 16'h3333);
    cyc("rr3", 3'b111, 0, 0, 3'b001, 16'hABCD);
    // DM write then DBG read back
    addr_dm = 8'h20;
    wdata_dm = 16'h1234;
    cyc("dm_wr", 3'b010, 0, 1, 3'b010, 16'h0000);
    addr_dbg = 8'h20;
    cyc("dbg_rd", 3'b100, 0, 0, 3'b100, 16'h1234);
    // ptr 0 -> IF grant sets ptr 1 so DM wins next
    cyc("if_pre", 3'b001, 0, 0, 3'b001, 16'hABCD);
    // lock bound: 4 DM grants then IF
    addr_dm = 8'h11;
    cyc("lk1", 3'b011, 1, 0, 3'b010, 16'h1111);
    cyc("lk2", 3'b011, 1, 0, 3'b010, 16'h1111);
    cyc("lk3", 3'b011, 1, 0, 3'b010, 16'h1111);
    cyc("lk4", 3'b011, 1, 0, 3'b010, 16'h1111);
    cyc("lk_if", 3'b011, 1, 0, 3'b001, 16'hABCD);
    // early release with DBG waiting (ptr = 1)
    addr_dbg = 8'h30;
    cyc("er1", 3'b110, 1, 0, 3'b010, 16'h1111);
    cyc("er2", 3'b110, 1, 0, 3'b010, 16'h1111);
    cyc("er_drop", 3'b100, 0, 0, 3'b000, 16'h0000);
    cyc("er_dbg", 3'b100, 0, 0, 3'b100, 16'h3333);
    // reset during pending read (ptr = 0 -> IF)
    req = 3'b001;
    #1;
    check("pr_gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    int_rst = 1'b1;
    req = 3'b111;
    #1;
    check("pr_rst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check("pr_rvalid", 32'(rvalid), 32'd0);
    #1;
    check("pr_rst_gnt2", 32'(gnt), 32'd0);
    check("pr_rst_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    check("pr_rvalid2", 32'(rvalid), 32'd0);
    int_rst = 1'b0;
    cyc("post_rst", 3'b111, 0, 0, 3'b001, 16'hABCD);
    req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
